scariv_vec_credit_return_master: RTL and testbench
==================================================

Name: scariv_vec_credit_return_master

Overview:
- Dispatch-side end of the credit-return protocol for a vector issue scheduler.
- Tracks the free entries remaining in the downstream scheduler and grants dispatch groups only when enough credits exist.
- Absorbs credit returns sent by the scheduler's credit-return slave, covering both finished entries and flush-ignored dispatches.
- Sits between the rename/dispatch stage and the VALU issue unit; also offers a drain handshake used before vtype-sensitive serialisation.

Parameters:
- MAX_CREDITS, 32, number of scheduler entries; reset and full credit level.
- MAX_REQ, 2, maximum credits consumed by one dispatch group (dispatch ports).
- CW, $clog2(MAX_CREDITS)+1, credit counter width (derived; not overridden).

Ports:
- i_clk  in  1  clock.
- i_reset  in  1  synchronous, active-high reset.
- i_get_credit  in  1  dispatch group requests credits this cycle.
- i_credit_val  in  $clog2(MAX_REQ)+1  credits requested; 0 is legal and always granted in RUN.
- o_grant  out  1  request accepted; credits deducted at the next edge.
- i_return_vld  in  1  credit return pulse from the scheduler slave.
- i_return_val  in  CW  credits returned with that pulse.
- i_drain_req  in  1  pulse: block grants until all credits are home.
- o_drain_done  out  1  one-cycle pulse when the drain completes.
- o_credits  out  CW  current available credits (registered).
- o_full  out  1  o_credits == MAX_CREDITS and no return is pending.

Behaviour:
- Reset (synchronous, i_reset=1 at the edge):
  - r_credits=MAX_CREDITS, state=RUN, return pipe cleared.
  - o_grant=0, o_drain_done=0, o_full=1.
  - Reset mid-drain or with a return in flight discards all pending state.
- Return pipe:
  - i_return_vld/i_return_val are registered into r_ret_vld/r_ret_val.
  - The registered value is added to r_credits at the following edge.
  - A return therefore appears on o_credits 2 cycles after its pulse.
  - Back-to-back returns are accepted every cycle.
- Grant (combinational):
  - o_grant = i_get_credit & (state==RUN) & (i_credit_val <= r_credits).
  - Returns still in the pipe are not counted toward a grant.
  - A partial grant never occurs; a denied request is simply retried by dispatch.
- Update each edge:
  - r_credits <= r_credits - (o_grant ? i_credit_val : 0) + (r_ret_vld ? r_ret_val : 0).
  - Evaluated at CW+1 bits; simultaneous grant and return are both applied in the same edge.
- Overflow: if the sum exceeds MAX_CREDITS, r_credits saturates at MAX_CREDITS. Underflow is impossible because of the grant rule.
- o_full = (r_credits==MAX_CREDITS) & ~r_ret_vld.
- FSM states: RUN, DRAIN.
  - RUN -> DRAIN on i_drain_req; o_grant is already suppressed from the following cycle.
  - In the same cycle as i_drain_req, a request may still be granted.
  - DRAIN -> RUN when o_full; o_drain_done=1 for exactly that cycle.
  - i_drain_req while in DRAIN is ignored.
  - If i_drain_req arrives while already full, DRAIN lasts one cycle and o_drain_done pulses on the next cycle.

Optional Feature:
- Macro: SCARIV_CREDIT_CHECK_EN.
- When defined:
  - Adds a sticky error register o_credit_err (output 1, reset 0).
  - Set on return overflow (sum > MAX_CREDITS).
  - Set on i_credit_val > MAX_REQ.
  - Set on i_return_val == 0 with i_return_vld.
  - Under SIMULATION, each of these also triggers $fatal with the offending values.
- When undefined:
  - The port is absent and overflow silently saturates.
  - All other behaviour is identical.

Decomposition:
- Shared package (scariv_vec_pkg):
  - credit_state_t enum {RUN, DRAIN}.
  - CW derivation function credit_width(max).
- Natural sub-module: scariv_credit_return_pipe, the registered return stage (vld/val flop plus clear on reset), reusable by the scalar schedulers' masters.

Test Plan (MAX_CREDITS=8, MAX_REQ=2):
- Reset, then idle -> o_credits=8, o_full=1, o_grant=0, o_drain_done=0.
- 4 consecutive requests of 2 -> all granted; o_credits 6,4,2,0; a fifth request of 1 has o_grant=0 and o_credits stays 0.
- From 0 credits, i_return_vld with val=3 at cycle t -> o_credits=3 at t+2; a request of 2 at t+1 is denied, at t+2 it is granted.
- Credits=1, same-cycle grant of 1 and registered return of 2 -> o_credits=2 next cycle.
- Credits=5, i_drain_req pulse, then returns 2 and 1 -> requests denied throughout DRAIN; o_drain_done pulses once when o_credits=8 with no pending return; grants resume the next cycle.
- With SCARIV_CREDIT_CHECK_EN: credits=8, return val=1 -> o_credits stays 8 and o_credit_err=1 sticky until reset. Without the macro: same saturation, and the port is absent.

Source files
------------

// File: rtl/scariv_vec_pkg.sv
// Shared types and helpers for the vector scheduler credit-return logic.
package scariv_vec_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } credit_state_t;

  // Wide enough to hold the full credit level itself, not just max-1.
  function automatic int credit_width(input int max);
    return $clog2(max) + 1;
  endfunction

endpackage

// File: rtl/scariv_credit_return_pipe.sv
// Registered credit-return stage; one flop of valid/value between the
// scheduler's credit-return slave and the master's credit counter.
module scariv_credit_return_pipe #(
  parameter int CW = 6
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_vld,
  input  logic [CW-1:0] i_val,
  output logic          o_vld,
  output logic [CW-1:0] o_val
);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_vld <= 1'b0;
      o_val <= '0;
    end else begin
      o_vld <= i_vld;
      o_val <= i_val;
    end
  end

endmodule

// File: rtl/scariv_vec_credit_return_master.sv
// Dispatch-side credit-return master for the vector issue scheduler.
// Optional sticky error checking is enabled with SCARIV_CREDIT_CHECK_EN.
module scariv_vec_credit_return_master
  import scariv_vec_pkg::*;
#(
  parameter  int MAX_CREDITS = 32,
  parameter  int MAX_REQ     = 2,
  localparam int CW          = credit_width(MAX_CREDITS),
  localparam int RW          = $clog2(MAX_REQ) + 1
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_get_credit,
  input  logic [RW-1:0] i_credit_val,
  output logic          o_grant,
  input  logic          i_return_vld,
  input  logic [CW-1:0] i_return_val,
  input  logic          i_drain_req,
  output logic          o_drain_done,
  output logic [CW-1:0] o_credits,
`ifdef SCARIV_CREDIT_CHECK_EN
  output logic          o_credit_err,
`endif
  output logic          o_full
);

  localparam logic [CW-1:0] FULL_LVL = CW'(MAX_CREDITS);

  credit_state_t r_state;
  credit_state_t w_state_next;
  logic [CW-1:0] r_credits;
  logic          r_ret_vld;
  logic [CW-1:0] r_ret_val;
  logic [CW-1:0] w_req;
  logic [CW:0]   w_sum;
  logic          w_overflow;

  scariv_credit_return_pipe #(.CW(CW)) u_ret_pipe (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_vld   (i_return_vld),
    .i_val   (i_return_val),
    .o_vld   (r_ret_vld),
    .o_val   (r_ret_val)
  );

  // Returns still sitting in the pipe are deliberately not counted here.
  assign w_req   = CW'(i_credit_val);
  assign o_grant = i_get_credit & (r_state == RUN) & (w_req <= r_credits);

  // One extra bit so a return on top of a nearly full counter cannot wrap.
  assign w_sum      = {1'b0, r_credits}
                    - (o_grant   ? {1'b0, w_req}     : '0)
                    + (r_ret_vld ? {1'b0, r_ret_val} : '0);
  assign w_overflow = (w_sum > {1'b0, FULL_LVL});

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_credits <= FULL_LVL;
      r_state   <= RUN;
    end else begin
      r_credits <= w_overflow ? FULL_LVL : w_sum[CW-1:0];
      r_state   <= w_state_next;
    end
  end

  assign o_full    = (r_credits == FULL_LVL) & ~r_ret_vld;
  assign o_credits = r_credits;

  always_comb begin
    w_state_next = r_state;
    o_drain_done = 1'b0;
    case (r_state)
      RUN: begin
        if (i_drain_req) w_state_next = DRAIN;
      end
      DRAIN: begin
        if (o_full) begin
          w_state_next = RUN;
          o_drain_done = 1'b1;
        end
      end
      default: w_state_next = RUN;
    endcase
  end

`ifdef SCARIV_CREDIT_CHECK_EN
  logic w_bad_req;
  logic w_bad_ret;

  assign w_bad_req = i_get_credit & (i_credit_val > RW'(MAX_REQ));
  assign w_bad_ret = i_return_vld & (i_return_val == '0);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_credit_err <= 1'b0;
    end else if (w_overflow | w_bad_req | w_bad_ret) begin
      o_credit_err <= 1'b1;
    end
  end

`ifdef SIMULATION
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      if (w_overflow)
        $fatal(1, "credit overflow: credits=%0d sum=%0d", r_credits, w_sum);
      if (w_bad_req)
        $fatal(1, "credit request too large: val=%0d", i_credit_val);
      if (w_bad_ret)
        $fatal(1, "zero-valued credit return");
    end
  end
`endif
`endif

endmodule

// File: tb/tb_scariv_vec_credit_return_master.sv
// Self-checking bench for scariv_vec_credit_return_master (MAX_CREDITS=8, MAX_REQ=2).
// Also checks o_credit_err when built with SCARIV_CREDIT_CHECK_EN.
module tb_scariv_vec_credit_return_master;

  localparam int MC = 8;
  localparam int MR = 2;
  localparam int CW = 4;
  localparam int RW = 2;

  typedef struct {
    bit get;
    int val;
    bit rv;
    int rval;
    bit drain;
    bit eg;
    int ec;
    bit ef;
    bit ed;
  } vec_t;

  logic          i_clk = 1'b0;
  logic          i_reset = 1'b1;
  logic          i_get_credit = 1'b0;
  logic [RW-1:0] i_credit_val = '0;
  logic          o_grant;
  logic          i_return_vld = 1'b0;
  logic [CW-1:0] i_return_val = '0;
  logic          i_drain_req = 1'b0;
  logic          o_drain_done;
  logic [CW-1:0] o_credits;
  logic          o_full;
`ifdef SCARIV_CREDIT_CHECK_EN
  logic          o_credit_err;
`endif

  scariv_vec_credit_return_master #(.MAX_CREDITS(MC), .MAX_REQ(MR)) dut (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_get_credit (i_get_credit),
    .i_credit_val (i_credit_val),
    .o_grant      (o_grant),
    .i_return_vld (i_return_vld),
    .i_return_val (i_return_val),
    .i_drain_req  (i_drain_req),
    .o_drain_done (o_drain_done),
    .o_credits    (o_credits),
`ifdef SCARIV_CREDIT_CHECK_EN
    .o_credit_err (o_credit_err),
`endif
    .o_full       (o_full)
  );

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: available credits, the one return in flight,
  // whether dispatch is draining, and the sticky error flag.
  int m_cred;
  bit m_pend_vld;
  int m_pend_val;
  bit m_drain;
  bit m_err;

  vec_t vecs[$];

  function automatic vec_t mk(bit get, int val, bit rv, int rval, bit drain,
                              bit eg, int ec, bit ef, bit ed);
    vec_t v;
    v.get = get; v.val = val; v.rv = rv; v.rval = rval; v.drain = drain;
    v.eg = eg; v.ec = ec; v.ef = ef; v.ed = ed;
    return v;
  endfunction

  function automatic vec_t modelExpect(vec_t v);
    vec_t r = v;
    r.ef = (m_cred == MC) && !m_pend_vld;
    r.eg = v.get && !m_drain && (v.val <= m_cred);
    r.ec = m_cred;
    r.ed = m_drain && r.ef;
    return r;
  endfunction

  task automatic modelReset();
    m_cred = MC; m_pend_vld = 0; m_pend_val = 0; m_drain = 0; m_err = 0;
  endtask

  task automatic modelAdvance(vec_t v);
    bit full  = (m_cred == MC) && !m_pend_vld;
    bit grant = v.get && !m_drain && (v.val <= m_cred);
    int sum   = m_cred - (grant ? v.val : 0) + (m_pend_vld ? m_pend_val : 0);
    if (sum > MC || (v.get && v.val > MR) || (v.rv && v.rval == 0)) m_err = 1;
    m_cred = (sum > MC) ? MC : sum;
    if (!m_drain && v.drain) m_drain = 1;
    else if (m_drain && full) m_drain = 0;
    m_pend_vld = v.rv;
    m_pend_val = v.rval;
  endtask

  task automatic compare(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle's inputs and let combinational outputs settle.
  task automatic applyStimulus(vec_t v);
    i_get_credit = v.get;
    i_credit_val = RW'(v.val);
    i_return_vld = v.rv;
    i_return_val = CW'(v.rval);
    i_drain_req  = v.drain;
    @(negedge i_clk);
  endtask

  task automatic checkOutput(vec_t v);
    compare("grant",      int'(o_grant),      int'(v.eg));
    compare("credits",    int'(o_credits),    v.ec);
    compare("full",       int'(o_full),       int'(v.ef));
    compare("drain_done", int'(o_drain_done), int'(v.ed));
`ifdef SCARIV_CREDIT_CHECK_EN
    compare("credit_err", int'(o_credit_err), int'(m_err));
`endif
  endtask

  task automatic finishCycle(vec_t v);
    @(posedge i_clk);
    modelAdvance(v);
    #1;
  endtask

  task automatic runVec(vec_t v);
    applyStimulus(v);
    checkOutput(v);
    finishCycle(v);
  endtask

  task automatic doReset();
    i_reset = 1'b1;
    i_get_credit = 0; i_credit_val = '0; i_return_vld = 0;
    i_return_val = '0; i_drain_req = 0;
    repeat (2) @(posedge i_clk);
    #1;
    i_reset = 1'b0;
    modelReset();
  endtask

  initial begin
    // Directed sequence: grant exhaustion, return latency, grant+return
    // in one edge, drain with pending returns, saturation, drain while full.
    vecs.push_back(mk(0,0,0,0,0, 0,8,1,0));
    vecs.push_back(mk(1,2,0,0,0, 1,8,1,0));
    vecs.push_back(mk(1,2,0,0,0, 1,6,0,0));
    vecs.push_back(mk(1,2,0,0,0, 1,4,0,0));
    vecs.push_back(mk(1,2,0,0,0, 1,2,0,0));
    vecs.push_back(mk(1,1,0,0,0, 0,0,0,0));
    vecs.push_back(mk(0,0,1,3,0, 0,0,0,0));
    vecs.push_back(mk(1,2,0,0,0, 0,0,0,0));
    vecs.push_back(mk(1,2,0,0,0, 1,3,0,0));
    vecs.push_back(mk(0,0,1,2,0, 0,1,0,0));
    vecs.push_back(mk(1,1,0,0,0, 1,1,0,0));
    vecs.push_back(mk(0,0,1,3,0, 0,2,0,0));
    vecs.push_back(mk(0,0,0,0,0, 0,2,0,0));
    vecs.push_back(mk(1,0,0,0,1, 1,5,0,0));
    vecs.push_back(mk(1,2,1,2,0, 0,5,0,0));
    vecs.push_back(mk(1,1,1,1,0, 0,5,0,0));
    vecs.push_back(mk(1,1,0,0,0, 0,7,0,0));
    vecs.push_back(mk(1,1,0,0,0, 0,8,1,1));
    vecs.push_back(mk(1,2,0,0,0, 1,8,1,0));
    vecs.push_back(mk(0,0,1,2,0, 0,6,0,0));
    vecs.push_back(mk(0,0,0,0,0, 0,6,0,0));
    vecs.push_back(mk(0,0,1,1,0, 0,8,1,0));
    vecs.push_back(mk(0,0,0,0,0, 0,8,0,0));
    vecs.push_back(mk(0,0,0,0,1, 0,8,1,0));
    vecs.push_back(mk(1,1,0,0,1, 0,8,1,1));
    vecs.push_back(mk(1,1,0,0,0, 1,8,1,0));
    vecs.push_back(mk(0,0,0,0,0, 0,7,0,0));

    $display("[TB] starting");
    doReset();
    foreach (vecs[i]) runVec(vecs[i]);

    // Reset while draining with a return in flight discards everything.
    runVec(mk(0,0,1,1,1, 0,7,0,0));
    doReset();
    runVec(mk(0,0,0,0,0, 0,8,1,0));
    runVec(mk(1,2,0,0,0, 1,8,1,0));
    runVec(mk(0,0,0,0,0, 0,6,0,0));

    // Random traffic against the reference model.
    for (int n = 0; n < 600; n++) begin
      vec_t v;
      if ($urandom_range(0, 99) == 0) begin
        doReset();
      end
      v.get   = ($urandom_range(0, 99) < 60);
      v.val   = $urandom_range(0, MR);
      v.rv    = ($urandom_range(0, 99) < 35);
      v.rval  = v.rv ? $urandom_range(1, 4) : 0;
      v.drain = ($urandom_range(0, 99) < 5);
      v = modelExpect(v);
      runVec(v);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
